// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, valid/ready on both sides.
// Optional signed-overflow output Ovf is enabled by defining ADD_OVF_FLAG_EN.
module pipelined_rca_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef ADD_OVF_FLAG_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int STAGES     = (WIDTH / CHUNK_SAFE < 1) ? 1 : WIDTH / CHUNK_SAFE;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_params
            $error("pipelined_rca_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // Handshake: a beat moves on every edge where advance is high; the whole
    // pipeline stalls together when the output holds a beat the sink refuses.
    logic advance;

    // Bank 0 latches the operands; bank k+1 holds the beat after slice k is added.
    logic                 vld_q [0:STAGES];
    logic                 c_q   [0:STAGES];
    logic [WIDTH-1:0]     s_q   [0:STAGES];
    logic [WIDTH-1:0]     a_q   [0:STAGES-1];
    logic [WIDTH-1:0]     b_q   [0:STAGES-1];
    logic [CHUNK_SAFE:0]  slice_t [0:STAGES-1];

    assign advance   = !vld_q[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES];
    assign S         = s_q[STAGES];
    assign Cout      = c_q[STAGES];

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_t[k] = {1'b0, a_q[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
                       + {1'b0, b_q[k][k*CHUNK_SAFE +: CHUNK_SAFE]}
                       + {{CHUNK_SAFE{1'b0}}, c_q[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= STAGES; k++) begin
                vld_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                s_q[k]   <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            a_q[0]   <= A;
            b_q[0]   <= B ^ {WIDTH{sub}};
            c_q[0]   <= sub ? 1'b1 : Cin;
            s_q[0]   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k+1] <= vld_q[k];
                c_q[k+1]   <= slice_t[k][CHUNK_SAFE];
                s_q[k+1]   <= s_q[k];
                s_q[k+1][k*CHUNK_SAFE +: CHUNK_SAFE] <= slice_t[k][CHUNK_SAFE-1:0];
                if (k + 1 < STAGES) begin
                    a_q[k+1] <= a_q[k];
                    b_q[k+1] <= b_q[k];
                end
            end
        end
    end

`ifdef ADD_OVF_FLAG_EN
    // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
    logic ovf_q;
    assign Ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                   ^ slice_t[STAGES-1][CHUNK_SAFE-1] ^ slice_t[STAGES-1][CHUNK_SAFE];
        end
    end
`endif

endmodule
